// File: rtl/tx_ofdm_pkg.sv
// Shared OFDM TX constants: frame geometry, pilot/null positions, constellation amplitudes.
package tx_ofdm_pkg;

  localparam int unsigned N     = 64;
  localparam int unsigned NDATA = 48;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned SYM_W = 4;

  // Fixed-point amplitudes, unity = 512 (Q9)
  localparam int PILOT_AMP = 512;
  localparam int QPSK_AMP  = 362;
  localparam int QAM_LO    = 162;
  localparam int QAM_HI    = 486;

  localparam logic [IDX_W-1:0] NULL_DC   = 6'd0;
  localparam logic [IDX_W-1:0] NULL_LO   = 6'd27;
  localparam logic [IDX_W-1:0] NULL_HI   = 6'd37;
  localparam logic [IDX_W-1:0] PILOT_0   = 6'd7;
  localparam logic [IDX_W-1:0] PILOT_NEG = 6'd21;
  localparam logic [IDX_W-1:0] PILOT_2   = 6'd43;
  localparam logic [IDX_W-1:0] PILOT_3   = 6'd57;

  typedef enum logic {ST_FILL, ST_EMIT} state_t;

  typedef enum logic [1:0] {SC_NULL, SC_PILOT_POS, SC_PILOT_NEG, SC_DATA} sc_kind_t;

  // Classify a subcarrier index into null / pilot / data.
  function automatic sc_kind_t sc_kind(input logic [IDX_W-1:0] idx);
    sc_kind_t k;
    k = SC_DATA;
    if (idx == NULL_DC || (idx >= NULL_LO && idx <= NULL_HI)) begin
      k = SC_NULL;
    end else if (idx == PILOT_NEG) begin
      k = SC_PILOT_NEG;
    end else if (idx == PILOT_0 || idx == PILOT_2 || idx == PILOT_3) begin
      k = SC_PILOT_POS;
    end
    return k;
  endfunction

endpackage

// File: rtl/qam_map.sv
// Combinational bits-to-I/Q mapper: QPSK (mode 0) or Gray-coded 16-QAM (mode 1).
module qam_map
  import tx_ofdm_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                    mode,
  input  logic [SYM_W-1:0]        bits,
  output logic signed [WIDTH-1:0] re,
  output logic signed [WIDTH-1:0] im
);

  // Gray level per axis: 00 -> -hi, 01 -> -lo, 11 -> +lo, 10 -> +hi
  function automatic logic signed [WIDTH-1:0] qam16_level(input logic [1:0] b);
    logic signed [WIDTH-1:0] v;
    v = '0;
    case (b)
      2'b00:   v = WIDTH'(-QAM_HI);
      2'b01:   v = WIDTH'(-QAM_LO);
      2'b11:   v = WIDTH'(QAM_LO);
      default: v = WIDTH'(QAM_HI);
    endcase
    return v;
  endfunction

  // Select constellation per latched frame mode.
  always_comb begin
    re = '0;
    im = '0;
    if (mode) begin
      re = qam16_level(bits[1:0]);
      im = qam16_level(bits[3:2]);
    end else begin
      re = bits[0] ? WIDTH'(QPSK_AMP) : WIDTH'(-QPSK_AMP);
      im = bits[1] ? WIDTH'(QPSK_AMP) : WIDTH'(-QPSK_AMP);
    end
  end

endmodule

// File: rtl/tx_subcarrier_mapper.sv
// Buffers 48 data symbols, then emits one 64-subcarrier OFDM frame with pilots and nulls.
module tx_subcarrier_mapper
  import tx_ofdm_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mode,
  input  logic                    di_en,
  input  logic [SYM_W-1:0]        di_bits,
  output logic                    di_rdy,
  output logic                    do_en,
  output logic                    do_sof,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im
);

  state_t                  state;
  logic [SYM_W-1:0]        buffer [NDATA];
  logic [IDX_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        dptr;
  logic                    mode_q;
  logic                    accept_c;
  sc_kind_t                kind_c;
  logic signed [WIDTH-1:0] map_re_c;
  logic signed [WIDTH-1:0] map_im_c;

  assign accept_c = di_en & di_rdy;
  assign kind_c   = sc_kind(idx);

  qam_map #(.WIDTH(WIDTH)) u_qam_map (
    .mode (mode_q),
    .bits (buffer[dptr]),
    .re   (map_re_c),
    .im   (map_im_c)
  );

  // Symbol store; contents need no reset since count gates their use.
  always_ff @(posedge clock) begin
    if (accept_c) begin
      buffer[cnt] <= di_bits;
    end
  end

  // FILL/EMIT control with registered sample outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_FILL;
      di_rdy <= 1'b1;
      cnt    <= '0;
      idx    <= '0;
      dptr   <= '0;
      mode_q <= 1'b0;
      do_en  <= 1'b0;
      do_sof <= 1'b0;
      do_re  <= '0;
      do_im  <= '0;
    end else begin
      do_en  <= 1'b0;
      do_sof <= 1'b0;
      do_re  <= '0;
      do_im  <= '0;
      case (state)
        ST_FILL: begin
          if (accept_c) begin
            if (cnt == '0) begin
              mode_q <= mode;
            end
            if (cnt == IDX_W'(NDATA - 1)) begin
              state  <= ST_EMIT;
              di_rdy <= 1'b0;
              cnt    <= '0;
              idx    <= '0;
              dptr   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_EMIT: begin
          do_en  <= 1'b1;
          do_sof <= (idx == '0);
          case (kind_c)
            SC_PILOT_POS: do_re <= WIDTH'(PILOT_AMP);
            SC_PILOT_NEG: do_re <= WIDTH'(-PILOT_AMP);
            SC_DATA: begin
              do_re <= map_re_c;
              do_im <= map_im_c;
              dptr  <= dptr + 1'b1;
            end
            default: ;
          endcase
          idx <= idx + 1'b1;
          if (idx == IDX_W'(N - 1)) begin
            state  <= ST_FILL;
            di_rdy <= 1'b1;
            dptr   <= '0;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_subcarrier_mapper.sv
// Randomized self-checking bench for tx_subcarrier_mapper against a frame-level reference model.
module tb_tx_subcarrier_mapper;

  localparam int unsigned WIDTH = 16;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    mode;
  logic                    di_en;
  logic [3:0]              di_bits;
  logic                    di_rdy;
  logic                    do_en;
  logic                    do_sof;
  logic signed [WIDTH-1:0] do_re;
  logic signed [WIDTH-1:0] do_im;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] acc_q[$];
  bit         frame_mode;
  int         exp_re[64];
  int         exp_im[64];
  logic [3:0] pat[4] = '{4'h0, 4'h5, 4'hF, 4'hA};

  tx_subcarrier_mapper #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset   (reset),
    .mode    (mode),
    .di_en   (di_en),
    .di_bits (di_bits),
    .di_rdy  (di_rdy),
    .do_en   (do_en),
    .do_sof  (do_sof),
    .do_re   (do_re),
    .do_im   (do_im)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-axis amplitude from the constellation tables.
  function automatic int level(input bit qam16, input logic [1:0] b);
    int lvl16[4] = '{-486, -162, 486, 162};
    if (qam16) return lvl16[b];
    return b[0] ? 362 : -362;
  endfunction

  // Expected 64-sample frame from the accepted symbols and the frame mode.
  task automatic build_model();
    int         d = 0;
    logic [3:0] s;
    for (int k = 0; k < 64; k++) begin
      if (k == 0 || (k >= 27 && k <= 37)) begin
        exp_re[k] = 0;    exp_im[k] = 0;
      end else if (k == 21) begin
        exp_re[k] = -512; exp_im[k] = 0;
      end else if (k == 7 || k == 43 || k == 57) begin
        exp_re[k] = 512;  exp_im[k] = 0;
      end else begin
        s = acc_q[d];
        d++;
        if (frame_mode) begin
          exp_re[k] = level(1'b1, s[1:0]);
          exp_im[k] = level(1'b1, s[3:2]);
        end else begin
          exp_re[k] = level(1'b0, {1'b0, s[0]});
          exp_im[k] = level(1'b0, {1'b0, s[1]});
        end
      end
    end
  endtask

  // pattern: 0 = constant 0x3, 1 = 0,5,F,A cycle, else random. Mode is m0 before sw_at accepts, m1 after.
  task automatic send_frame(input int pattern, input int en_pct, input bit m0, input int sw_at, input bit m1);
    int n = 0;
    int guard = 0;
    acc_q.delete();
    while (n < 48 && guard < 4000) begin
      @(negedge clock);
      check("rdy_fill", int'(di_rdy), 1);
      di_en = ($urandom_range(99) < en_pct);
      mode  = (n < sw_at) ? m0 : m1;
      case (pattern)
        0:       di_bits = 4'h3;
        1:       di_bits = pat[n % 4];
        default: di_bits = 4'($urandom);
      endcase
      @(posedge clock);
      if (di_en) begin
        if (n == 0) frame_mode = mode;
        acc_q.push_back(di_bits);
        n++;
      end
      guard++;
    end
    if (n < 48) check("fill_timeout", n, 48);
  endtask

  // Check one emitted frame; optionally hold di_en high and/or reset at sample abort_at.
  task automatic collect_frame(input bit hold_en, input int abort_at);
    int seen;
    build_model();
    @(negedge clock);
    check("en_before_first", int'(do_en), 0);
    check("rdy_emit_start", int'(di_rdy), 0);
    di_en   = hold_en;
    di_bits = 4'h6;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      check($sformatf("en[%0d]", k), int'(do_en), 1);
      check($sformatf("sof[%0d]", k), int'(do_sof), int'(k == 0));
      check($sformatf("re[%0d]", k), int'(do_re), exp_re[k]);
      check($sformatf("im[%0d]", k), int'(do_im), exp_im[k]);
      check($sformatf("rdy[%0d]", k), int'(di_rdy), int'(k == 63));
      di_en = hold_en && (k < 63);
      if (k == abort_at) begin
        reset = 1'b1;
        di_en = 1'b0;
        @(negedge clock);
        check("abort_en", int'(do_en), 0);
        check("abort_sof", int'(do_sof), 0);
        check("abort_re", int'(do_re), 0);
        check("abort_rdy", int'(di_rdy), 1);
        reset = 1'b0;
        seen  = 0;
        repeat (70) begin
          @(negedge clock);
          seen += int'(do_en);
        end
        check("abort_quiet", seen, 0);
        return;
      end
    end
    di_en = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    mode    = 1'b0;
    di_en   = 1'b0;
    di_bits = 4'h0;
    @(negedge clock);
    @(negedge clock);
    check("rst_rdy", int'(di_rdy), 1);
    check("rst_en", int'(do_en), 0);
    check("rst_sof", int'(do_sof), 0);
    check("rst_re", int'(do_re), 0);
    check("rst_im", int'(do_im), 0);
    reset = 1'b0;

    send_frame(0, 100, 1'b0, 64, 1'b0); collect_frame(1'b0, -1);  // QPSK 0x3
    send_frame(1, 100, 1'b1, 64, 1'b1); collect_frame(1'b0, -1);  // 16-QAM corner cycle
    send_frame(2, 50,  1'b1, 64, 1'b1); collect_frame(1'b0, -1);  // gappy fill
    send_frame(2, 70,  1'b0, 64, 1'b0); collect_frame(1'b1, -1);  // di_en held in EMIT
    send_frame(1, 100, 1'b1, 64, 1'b1); collect_frame(1'b0, -1);  // order after held di_en
    send_frame(2, 80,  1'b1, 10, 1'b0); collect_frame(1'b0, -1);  // mode switch after 10
    send_frame(2, 60,  1'b1, 64, 1'b1); collect_frame(1'b0, 30);  // reset mid-EMIT
    send_frame(2, 60,  1'b0, 64, 1'b0); collect_frame(1'b0, -1);  // recovery frame

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
